l4_header_parser: RTL and testbench

Sits directly downstream of the IPv4 parser and consumes its registered pass-through stream and extracted addresses. Walks past the IPv4 header using the IHL in the stream, then extracts the TCP/UDP header fields. Emits a one-cycle-valid 5-tuple plus flags to the flow/classification stage, and forwards the stream unchanged with one cycle of latency.

---
 rtl/parser_pkg.sv | 28 ++
 rtl/l4_header_parser.sv | 214 +++++++++++++++++++++
 tb/tb_l4_header_parser.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parser_pkg.sv
// rtl/parser_pkg.sv - shared definitions for the L4 header parser
//   l4_state_t      : walk state of the L4 header parser
//   IPPROTO_*       : IPv4 protocol numbers the parser accepts
//   IPV4_MIN_IHL    : smallest legal IPv4 header length in 32-bit words
//   *_REQ_BYTES     : L4 header bytes needed before the 5-tuple is complete
//   l4_req_bytes()  : required L4 byte count for a given protocol
package parser_pkg;

    typedef enum logic [2:0] {
        L4_IDLE    = 3'd0,
        L4_IP_HDR  = 3'd1,
        L4_L4_HDR  = 3'd2,
        L4_PAYLOAD = 3'd3,
        L4_DROP    = 3'd4
    } l4_state_t;

    localparam logic [7:0] IPPROTO_TCP   = 8'd6;
    localparam logic [7:0] IPPROTO_UDP   = 8'd17;
    localparam logic [3:0] IPV4_MIN_IHL  = 4'd5;
    localparam int         UDP_REQ_BYTES = 6;
    localparam int         TCP_REQ_BYTES = 14;

    // Only called once the protocol is known to be TCP or UDP.
    function automatic logic [15:0] l4_req_bytes(input logic [7:0] proto);
        return (proto == IPPROTO_TCP) ? 16'(TCP_REQ_BYTES) : 16'(UDP_REQ_BYTES);
    endfunction

endpackage

// File: rtl/l4_header_parser.sv
// rtl/l4_header_parser.sv - TCP/UDP 5-tuple extractor behind the IPv4 parser
//   clk, rst                     : clock, asynchronous active-high reset
//   tdata_in, idx_in             : frame bytes (lane 0 first), count of valid lanes
//   data_valid_in, last_flag_in  : beat qualifier, final beat of frame
//   ipv4_parser_ready            : upstream src_ip/dst_ip are valid
//   src_ip, dst_ip               : upstream-extracted addresses
//   tdata_out .. last_flag_out   : stream pass-through, one register stage
//   src_port, dst_port           : L4 ports
//   flow_src_ip, flow_dst_ip     : addresses latched with a good 5-tuple
//   l4_protocol, tcp_flags       : protocol number, TCP flags byte (0 for UDP)
//   udp_length                   : UDP length field (0 for TCP)
//   l4_valid, l4_error           : one-cycle result / failure pulses
module l4_header_parser
    import parser_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    localparam int IDXW       = $clog2(DATA_WIDTH / 8 + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tdata_in,
    input  logic [IDXW-1:0]       idx_in,
    input  logic                  data_valid_in,
    input  logic                  last_flag_in,
    input  logic                  ipv4_parser_ready,
    input  logic [31:0]           src_ip,
    input  logic [31:0]           dst_ip,
    output logic [DATA_WIDTH-1:0] tdata_out,
    output logic [IDXW-1:0]       idx_out,
    output logic                  data_valid_out,
    output logic                  last_flag_out,
    output logic [15:0]           src_port,
    output logic [15:0]           dst_port,
    output logic [31:0]           flow_src_ip,
    output logic [31:0]           flow_dst_ip,
    output logic [7:0]            l4_protocol,
    output logic [7:0]            tcp_flags,
    output logic [15:0]           udp_length,
    output logic                  l4_valid,
    output logic                  l4_error
);

    localparam int LANES = DATA_WIDTH / 8;

    l4_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  ver_q, ver_d;
    logic [3:0]  ihl_q, ihl_d;
    logic [7:0]  proto_q, proto_d;
    logic [5:0]  hlen_q, hlen_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] dp_q, dp_d;
    logic [15:0] ulen_q, ulen_d;
    logic [7:0]  flags_q, flags_d;
    logic        done_d;
    logic        trunc_d;
    logic [7:0]  lane_byte;
    logic [15:0] l4_off;

    // Walks every valid lane of the beat in order, so a single beat can
    // finish the IPv4 header, enter L4_HDR and complete the 5-tuple.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ver_d     = ver_q;
        ihl_d     = ihl_q;
        proto_d   = proto_q;
        hlen_d    = hlen_q;
        sp_d      = sp_q;
        dp_d      = dp_q;
        ulen_d    = ulen_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        trunc_d   = 1'b0;
        lane_byte = 8'd0;
        l4_off    = 16'd0;

        if (data_valid_in) begin
            if (state_d == L4_IDLE) begin
                state_d = L4_IP_HDR;
                cnt_d   = 16'd0;
                ver_d   = 4'd0;
                ihl_d   = 4'd0;
                proto_d = 8'd0;
                hlen_d  = 6'd0;
                sp_d    = 16'd0;
                dp_d    = 16'd0;
                ulen_d  = 16'd0;
                flags_d = 8'd0;
            end

            for (int i = 0; i < LANES; i++) begin
                if (i < int'(idx_in)) begin
                    lane_byte = tdata_in[i*8 +: 8];
                    l4_off    = cnt_d - {10'd0, hlen_d};
                    case (state_d)
                        L4_IP_HDR: begin
                            if (cnt_d == 16'd0) begin
                                ver_d  = lane_byte[7:4];
                                ihl_d  = lane_byte[3:0];
                                hlen_d = {lane_byte[3:0], 2'b00};
                            end
                            if (cnt_d == 16'd9) begin
                                proto_d = lane_byte;
                                if (ver_d != 4'd4 || ihl_d < IPV4_MIN_IHL ||
                                    !(lane_byte == IPPROTO_TCP || lane_byte == IPPROTO_UDP)) begin
                                    state_d = L4_DROP;
                                end
                            end
                        end
                        L4_L4_HDR: begin
                            case (l4_off)
                                16'd0:  sp_d[15:8] = lane_byte;
                                16'd1:  sp_d[7:0]  = lane_byte;
                                16'd2:  dp_d[15:8] = lane_byte;
                                16'd3:  dp_d[7:0]  = lane_byte;
                                16'd4:  if (proto_d == IPPROTO_UDP) ulen_d[15:8] = lane_byte;
                                16'd5:  if (proto_d == IPPROTO_UDP) ulen_d[7:0]  = lane_byte;
                                16'd13: if (proto_d == IPPROTO_TCP) flags_d      = lane_byte;
                                default: ;
                            endcase
                            if (l4_off == l4_req_bytes(proto_d) - 16'd1) begin
                                state_d = L4_PAYLOAD;
                                done_d  = 1'b1;
                            end
                        end
                        default: ;
                    endcase

                    if (cnt_d != 16'hFFFF) begin
                        cnt_d = cnt_d + 16'd1;
                    end

                    // The cnt > 9 guard keeps a bogus short IHL from entering
                    // L4_HDR before the header check at offset 9 has run.
                    if (state_d == L4_IP_HDR && cnt_d > 16'd9 && cnt_d == {10'd0, hlen_d}) begin
                        state_d = L4_L4_HDR;
                    end
                end
            end

            // A 5-tuple completed in this beat has already moved to PAYLOAD,
            // so a coincident last is a clean end, not a truncation.
            if (last_flag_in) begin
                if (state_d == L4_IP_HDR || state_d == L4_L4_HDR) begin
                    trunc_d = 1'b1;
                end
                state_d = L4_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= L4_IDLE;
            cnt_q          <= 16'd0;
            ver_q          <= 4'd0;
            ihl_q          <= 4'd0;
            proto_q        <= 8'd0;
            hlen_q         <= 6'd0;
            sp_q           <= 16'd0;
            dp_q           <= 16'd0;
            ulen_q         <= 16'd0;
            flags_q        <= 8'd0;
            tdata_out      <= '0;
            idx_out        <= '0;
            data_valid_out <= 1'b0;
            last_flag_out  <= 1'b0;
            src_port       <= 16'd0;
            dst_port       <= 16'd0;
            flow_src_ip    <= 32'd0;
            flow_dst_ip    <= 32'd0;
            l4_protocol    <= 8'd0;
            tcp_flags      <= 8'd0;
            udp_length     <= 16'd0;
            l4_valid       <= 1'b0;
            l4_error       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ver_q          <= ver_d;
            ihl_q          <= ihl_d;
            proto_q        <= proto_d;
            hlen_q         <= hlen_d;
            sp_q           <= sp_d;
            dp_q           <= dp_d;
            ulen_q         <= ulen_d;
            flags_q        <= flags_d;

            tdata_out      <= tdata_in;
            idx_out        <= idx_in;
            data_valid_out <= data_valid_in;
            last_flag_out  <= last_flag_in;

            l4_valid       <= done_d & ipv4_parser_ready;
            l4_error       <= (done_d & ~ipv4_parser_ready) | trunc_d;

            // Ports and L4 fields follow every completed header; addresses
            // only when upstream vouches for them.
            if (done_d) begin
                src_port    <= sp_d;
                dst_port    <= dp_d;
                l4_protocol <= proto_d;
                tcp_flags   <= flags_d;
                udp_length  <= ulen_d;
                if (ipv4_parser_ready) begin
                    flow_src_ip <= src_ip;
                    flow_dst_ip <= dst_ip;
                end
            end
        end
    end

endmodule

// File: tb/tb_l4_header_parser.sv
// tb/tb_l4_header_parser.sv - directed self-checking bench for l4_header_parser
module tb_l4_header_parser;

    localparam int DW   = 64;
    localparam int IDXW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   tdata_in;
    logic [IDXW-1:0] idx_in;
    logic            data_valid_in;
    logic            last_flag_in;
    logic            ipv4_parser_ready;
    logic [31:0]     src_ip, dst_ip;
    logic [DW-1:0]   tdata_out;
    logic [IDXW-1:0] idx_out;
    logic            data_valid_out, last_flag_out;
    logic [15:0]     src_port, dst_port, udp_length;
    logic [31:0]     flow_src_ip, flow_dst_ip;
    logic [7:0]      l4_protocol, tcp_flags;
    logic            l4_valid, l4_error;

    l4_header_parser #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .tdata_in(tdata_in), .idx_in(idx_in),
        .data_valid_in(data_valid_in), .last_flag_in(last_flag_in),
        .ipv4_parser_ready(ipv4_parser_ready),
        .src_ip(src_ip), .dst_ip(dst_ip),
        .tdata_out(tdata_out), .idx_out(idx_out),
        .data_valid_out(data_valid_out), .last_flag_out(last_flag_out),
        .src_port(src_port), .dst_port(dst_port),
        .flow_src_ip(flow_src_ip), .flow_dst_ip(flow_dst_ip),
        .l4_protocol(l4_protocol), .tcp_flags(tcp_flags),
        .udp_length(udp_length), .l4_valid(l4_valid), .l4_error(l4_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int valid_cyc = -1;
    int beat_cyc[32];
    bit mon_on   = 1'b0;

    logic [15:0] cap_sp, cap_dp, cap_len;
    logic [7:0]  cap_proto, cap_flags;
    logic [31:0] cap_fsrc, cap_fdst;

    logic [DW-1:0]   exp_tdata;
    logic [IDXW-1:0] exp_idx;
    logic            exp_dv, exp_last;

    logic [7:0] frm[$];

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_tdata <= '0;
            exp_idx   <= '0;
            exp_dv    <= 1'b0;
            exp_last  <= 1'b0;
        end else begin
            exp_tdata <= tdata_in;
            exp_idx   <= idx_in;
            exp_dv    <= data_valid_in;
            exp_last  <= last_flag_in;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if ({tdata_out, idx_out, data_valid_out, last_flag_out} !== {exp_tdata, exp_idx, exp_dv, exp_last}) begin
                failures++;
                $display("FAIL passthrough cyc=%0d got=%h/%0d/%b/%b want=%h/%0d/%b/%b", cyc,
                         tdata_out, idx_out, data_valid_out, last_flag_out, exp_tdata, exp_idx, exp_dv, exp_last);
            end
            checks++;
            if (l4_valid === 1'b1 && l4_error === 1'b1) begin
                failures++;
                $display("FAIL valid_error_exclusive cyc=%0d got both=1 want not both", cyc);
            end
            if (l4_valid === 1'b1) begin
                n_valid++;
                valid_cyc = cyc;
                cap_sp    = src_port;
                cap_dp    = dst_port;
                cap_len   = udp_length;
                cap_proto = l4_protocol;
                cap_flags = tcp_flags;
                cap_fsrc  = flow_src_ip;
                cap_fdst  = flow_dst_ip;
            end
            if (l4_error === 1'b1) n_err++;
        end
    end

    task automatic build_frame(input logic [3:0] ver, input logic [3:0] ihl, input logic [7:0] proto,
                               input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ulen,
                               input logic [7:0] flags);
        frm.delete();
        frm.push_back({ver, ihl});
        for (int k = 1; k < 9; k++) frm.push_back(8'h00);
        frm.push_back(proto);
        frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'd10); frm.push_back(8'd0); frm.push_back(8'd0); frm.push_back(8'd1);
        frm.push_back(8'd10); frm.push_back(8'd0); frm.push_back(8'd0); frm.push_back(8'd2);
        for (int k = 20; k < int'(ihl) * 4; k++) frm.push_back(8'hEE);
        frm.push_back(sp[15:8]); frm.push_back(sp[7:0]);
        frm.push_back(dp[15:8]); frm.push_back(dp[7:0]);
        if (proto == 8'd17) begin
            frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
            frm.push_back(8'h00); frm.push_back(8'h00);
        end else begin
            for (int k = 0; k < 8; k++) frm.push_back(8'h30 + 8'(k));
            frm.push_back(8'h50);
            frm.push_back(flags);
            for (int k = 0; k < 6; k++) frm.push_back(8'h77);
        end
        for (int k = 0; k < 20; k++) frm.push_back(8'hA0 + 8'(k));
    endtask

    // nbytes=0 sends the whole frame; with_last=0 leaves the frame open.
    task automatic send(input int lanes, input bit zero_last, input bit with_last, input int nbytes);
        int pos, total, n, nb;
        pos   = 0;
        nb    = 0;
        total = (nbytes > 0) ? nbytes : frm.size();
        while (pos < total) begin
            n = (total - pos < lanes) ? (total - pos) : lanes;
            tdata_in = '0;
            for (int k = 0; k < n; k++) tdata_in[k*8 +: 8] = frm[pos+k];
            idx_in        = IDXW'(n);
            data_valid_in = 1'b1;
            last_flag_in  = with_last && !zero_last && (pos + n == total);
            @(posedge clk); #1;
            beat_cyc[nb] = cyc;
            nb++;
            pos += n;
        end
        if (zero_last && with_last) begin
            tdata_in      = '0;
            idx_in        = '0;
            data_valid_in = 1'b1;
            last_flag_in  = 1'b1;
            @(posedge clk); #1;
        end
        data_valid_in = 1'b0;
        last_flag_in  = 1'b0;
        tdata_in      = {DW/32{32'hDEADBEEF}};
        idx_in        = IDXW'(5);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tdata_in = '0; idx_in = '0; data_valid_in = 1'b0; last_flag_in = 1'b0;
        ipv4_parser_ready = 1'b0; src_ip = 32'd0; dst_ip = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({l4_valid, l4_error} !== 2'b00) begin
            failures++; $display("FAIL reset_pulses got=%b want=00", {l4_valid, l4_error});
        end
        checks++;
        if ({src_port, dst_port, udp_length, l4_protocol, tcp_flags} !== 64'd0) begin
            failures++; $display("FAIL reset_fields got=%h want=0", {src_port, dst_port, udp_length, l4_protocol, tcp_flags});
        end
        checks++;
        if ({flow_src_ip, flow_dst_ip, tdata_out, idx_out, data_valid_out, last_flag_out} !== '0) begin
            failures++; $display("FAIL reset_stream got=%h/%h/%h want=0", flow_src_ip, flow_dst_ip, tdata_out);
        end
        rst = 1'b0;
        mon_on = 1'b1;
        idle(2);
    endtask

    task automatic test_udp;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        ipv4_parser_ready = 1'b1; src_ip = 32'h0A000001; dst_ip = 32'h0A000002;
        build_frame(4'd4, 4'd5, 8'd17, 16'h1234, 16'h0035, 16'h001C, 8'h00);
        send(8, 1'b0, 1'b1, 0);
        idle(2);
        checks++; if (n_valid !== v0 + 1) begin failures++; $display("FAIL udp_valid_count got=%0d want=%0d", n_valid - v0, 1); end
        checks++; if (n_err !== e0) begin failures++; $display("FAIL udp_err_count got=%0d want=0", n_err - e0); end
        checks++; if (valid_cyc !== beat_cyc[3]) begin failures++; $display("FAIL udp_valid_timing got=%0d want=%0d", valid_cyc, beat_cyc[3]); end
        checks++; if ({cap_sp, cap_dp} !== 32'h1234_0035) begin failures++; $display("FAIL udp_ports got=%h want=12340035", {cap_sp, cap_dp}); end
        checks++; if ({cap_len, cap_flags, cap_proto} !== 32'h001C_00_11) begin failures++; $display("FAIL udp_fields got=%h want=001c0011", {cap_len, cap_flags, cap_proto}); end
        checks++; if ({cap_fsrc, cap_fdst} !== 64'h0A000001_0A000002) begin failures++; $display("FAIL udp_flow_ip got=%h want=0a0000010a000002", {cap_fsrc, cap_fdst}); end
    endtask

    task automatic test_tcp;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        src_ip = 32'hC0A80101; dst_ip = 32'hC0A80102;
        build_frame(4'd4, 4'd6, 8'd6, 16'h0050, 16'hC000, 16'h0000, 8'h12);
        send(8, 1'b0, 1'b1, 0);
        idle(2);
        checks++; if (n_valid !== v0 + 1 || n_err !== e0) begin failures++; $display("FAIL tcp_counts got=%0d/%0d want=1/0", n_valid - v0, n_err - e0); end
        checks++; if (valid_cyc !== beat_cyc[4]) begin failures++; $display("FAIL tcp_valid_timing got=%0d want=%0d", valid_cyc, beat_cyc[4]); end
        checks++; if ({cap_sp, cap_dp} !== 32'h0050_C000) begin failures++; $display("FAIL tcp_ports got=%h want=0050c000", {cap_sp, cap_dp}); end
        checks++; if ({cap_len, cap_flags, cap_proto} !== 32'h0000_12_06) begin failures++; $display("FAIL tcp_fields got=%h want=00001206", {cap_len, cap_flags, cap_proto}); end
        checks++; if ({cap_fsrc, cap_fdst} !== 64'hC0A80101_C0A80102) begin failures++; $display("FAIL tcp_flow_ip got=%h want=c0a80101c0a80102", {cap_fsrc, cap_fdst}); end
    endtask

    task automatic test_drop;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        build_frame(4'd4, 4'd5, 8'd1, 16'h1111, 16'h2222, 16'h0010, 8'h00);
        send(8, 1'b0, 1'b1, 0);
        build_frame(4'd6, 4'd5, 8'd17, 16'h3333, 16'h4444, 16'h0010, 8'h00);
        send(8, 1'b0, 1'b1, 0);
        idle(2);
        checks++; if (n_valid !== v0) begin failures++; $display("FAIL drop_no_valid got=%0d want=0", n_valid - v0); end
        checks++; if (n_err !== e0) begin failures++; $display("FAIL drop_no_error got=%0d want=0", n_err - e0); end
        checks++; if ({src_port, tcp_flags} !== 24'h0050_12) begin failures++; $display("FAIL drop_fields_hold got=%h want=005012", {src_port, tcp_flags}); end
    endtask

    task automatic test_back_to_back;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        src_ip = 32'h0A000001; dst_ip = 32'h0A000002;
        build_frame(4'd4, 4'd5, 8'd17, 16'h1234, 16'h0035, 16'h001C, 8'h00);
        send(8, 1'b0, 1'b1, 23);
        build_frame(4'd4, 4'd5, 8'd17, 16'hABCD, 16'h0101, 16'h0010, 8'h00);
        send(8, 1'b0, 1'b1, 0);
        idle(2);
        checks++; if (n_err !== e0 + 1) begin failures++; $display("FAIL trunc_error_count got=%0d want=1", n_err - e0); end
        checks++; if (n_valid !== v0 + 1) begin failures++; $display("FAIL trunc_valid_count got=%0d want=1", n_valid - v0); end
        checks++; if ({cap_sp, cap_dp, cap_len} !== 48'hABCD_0101_0010) begin failures++; $display("FAIL b2b_fields got=%h want=abcd01010010", {cap_sp, cap_dp, cap_len}); end
    endtask

    task automatic test_partial;
        int lanes_tab[3] = '{3, 5, 8};
        int v0;
        for (int t = 0; t < 3; t++) begin
            v0 = n_valid;
            cap_sp = 16'h0; cap_dp = 16'h0; cap_len = 16'h0;
            build_frame(4'd4, 4'd5, 8'd17, 16'h1234, 16'h0035, 16'h001C, 8'h00);
            send(lanes_tab[t], lanes_tab[t] == 8, 1'b1, 0);
            idle(2);
            checks++; if (n_valid !== v0 + 1) begin failures++; $display("FAIL partial_%0d_count got=%0d want=1", lanes_tab[t], n_valid - v0); end
            checks++; if ({cap_sp, cap_dp, cap_len, cap_proto} !== 56'h1234_0035_001C_11) begin
                failures++; $display("FAIL partial_%0d_fields got=%h want=12340035001c11", lanes_tab[t], {cap_sp, cap_dp, cap_len, cap_proto});
            end
        end
    endtask

    task automatic test_not_ready;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        ipv4_parser_ready = 1'b0; src_ip = 32'h01020304; dst_ip = 32'h05060708;
        build_frame(4'd4, 4'd5, 8'd17, 16'h4444, 16'h5555, 16'h0020, 8'h00);
        send(8, 1'b0, 1'b1, 0);
        idle(2);
        checks++; if (n_err !== e0 + 1 || n_valid !== v0) begin failures++; $display("FAIL notready_counts got=%0d/%0d want=0/1", n_valid - v0, n_err - e0); end
        checks++; if ({src_port, dst_port} !== 32'h4444_5555) begin failures++; $display("FAIL notready_ports got=%h want=44445555", {src_port, dst_port}); end
        checks++; if ({flow_src_ip, flow_dst_ip} !== 64'h0A000001_0A000002) begin failures++; $display("FAIL notready_ip_hold got=%h want=0a0000010a000002", {flow_src_ip, flow_dst_ip}); end
        ipv4_parser_ready = 1'b1; src_ip = 32'h0A000001; dst_ip = 32'h0A000002;
    endtask

    task automatic test_reset_mid;
        int v0, e0;
        build_frame(4'd4, 4'd5, 8'd17, 16'h7777, 16'h8888, 16'h0030, 8'h00);
        send(8, 1'b0, 1'b0, 24);
        rst = 1'b1;
        #2;
        checks++;
        if ({src_port, dst_port, udp_length, l4_protocol, tcp_flags, flow_src_ip, flow_dst_ip,
             l4_valid, l4_error, tdata_out, idx_out, data_valid_out, last_flag_out} !== '0) begin
            failures++; $display("FAIL midreset_outputs got=%h/%h/%h want=0", {src_port, dst_port}, flow_src_ip, tdata_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        v0 = n_valid; e0 = n_err;
        build_frame(4'd4, 4'd5, 8'd17, 16'h1234, 16'h0035, 16'h001C, 8'h00);
        send(8, 1'b0, 1'b1, 0);
        idle(2);
        checks++; if (n_valid !== v0 + 1 || n_err !== e0) begin failures++; $display("FAIL midreset_counts got=%0d/%0d want=1/0", n_valid - v0, n_err - e0); end
        checks++; if ({cap_sp, cap_dp, cap_len, cap_fsrc} !== 80'h1234_0035_001C_0A000001) begin
            failures++; $display("FAIL midreset_fields got=%h want=12340035001c0a000001", {cap_sp, cap_dp, cap_len, cap_fsrc});
        end
    endtask

    initial begin
        test_reset;
        test_udp;
        test_tcp;
        test_drop;
        test_back_to_back;
        test_partial;
        test_not_ready;
        test_reset_mid;
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
